// File: rtl/prog_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words and writes them to instruction memory.
// Optional trailing checksum byte compiled in with `define LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          NUM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] words_written,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready never depends on in_valid.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd3,
`endif
    S_DONE    = 3'd4
  } state_t;

  localparam logic [31:0] LP_NUM_WORDS = 32'(NUM_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic [31:0] r_words_written;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        w_xfer;
  logic        w_last_word;

  assign w_xfer        = in_valid && in_ready;
  assign w_last_word   = (r_words_written + 32'd1) == LP_NUM_WORDS;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign words_written = r_words_written;
  assign dbg_state     = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_COLLECT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_COLLECT;
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer && (r_byte_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        w_next = w_last_word ? S_CHECK : S_COLLECT;
`else
        w_next = w_last_word ? S_DONE : S_COLLECT;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer) w_next = S_DONE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Address/data are captured with the 4th byte so they are stable through WRITE and held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_idx      <= 2'd0;
      r_word          <= 24'd0;
      r_words_written <= 32'd0;
      r_mem_addr      <= 32'd0;
      r_mem_wdata     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      r_sum           <= 8'd0;
      r_err           <= 1'b0;
`endif
    end else begin
      if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) begin
        r_byte_idx      <= 2'd0;
        r_words_written <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
        r_sum           <= 8'd0;
        r_err           <= 1'b0;
`endif
      end
      if ((r_state == S_COLLECT) && w_xfer) begin
        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        r_sum      <= r_sum + in_data;
`endif
        case (r_byte_idx)
          2'd0: r_word[7:0]   <= in_data;
          2'd1: r_word[15:8]  <= in_data;
          2'd2: r_word[23:16] <= in_data;
          default: begin
            r_mem_addr  <= BASE_ADDR + (r_words_written << 2);
            r_mem_wdata <= {in_data, r_word};
          end
        endcase
      end
      if (r_state == S_WRITE) r_words_written <= r_words_written + 32'd1;
`ifdef LOADER_CHECKSUM_EN
      if ((r_state == S_CHECK) && w_xfer) r_err <= (in_data != r_sum);
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (BASE 0 / 2 words, BASE 0x100 / 1 word), directed byte vectors,
// expected writes queued at stimulus time and popped by a write monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s    [2];
  logic        in_valid_s [2];
  logic [7:0]  in_data_s  [2];
  logic        in_ready_s [2];
  logic        mem_we_s   [2];
  logic [31:0] mem_addr_s [2];
  logic [31:0] mem_wdata_s[2];
  logic        busy_s     [2];
  logic        done_s     [2];
  logic [31:0] words_s    [2];
  logic        err_s      [2];
  logic [2:0]  state_s    [2];

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(32'h0), .NUM_WORDS(2)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
    .in_ready(in_ready_s[0]), .mem_we(mem_we_s[0]), .mem_addr(mem_addr_s[0]), .mem_wdata(mem_wdata_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .words_written(words_s[0]), .err(err_s[0]), .dbg_state(state_s[0])
  );

  prog_loader #(.BASE_ADDR(32'h100), .NUM_WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
    .in_ready(in_ready_s[1]), .mem_we(mem_we_s[1]), .mem_addr(mem_addr_s[1]), .mem_wdata(mem_wdata_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .words_written(words_s[1]), .err(err_s[1]), .dbg_state(state_s[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of that instance's expected queue.
  logic        prev_we[2];
  logic [63:0] mon_e;
  bit          mon_has;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        prev_we[d] = 1'b0;
      end else begin
        if (mem_we_s[d]) begin
          mon_has = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          if (!mon_has) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write dut%0d: got addr 0x%08h data 0x%08h expected no write",
                     d, mem_addr_s[d], mem_wdata_s[d]);
          end else begin
            mon_e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("write_addr_dut%0d", d), mem_addr_s[d], mon_e[63:32]);
            check($sformatf("write_data_dut%0d", d), mem_wdata_s[d], mon_e[31:0]);
            check($sformatf("we_single_cycle_dut%0d", d), {31'd0, prev_we[d]}, 32'd0);
          end
        end
        prev_we[d] = mem_we_s[d];
      end
    end
  end

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit gap);
    bit rdy;
    int n;
    n = 0;
    in_valid_s[d] = 1'b1;
    in_data_s[d]  = b;
    do begin
      @(negedge clk);
      rdy = in_ready_s[d];
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    in_valid_s[d] = 1'b0;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout dut%0d: got no ready in 100 cycles expected ready", d);
    end
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input int d, input logic [31:0] addr, input logic [31:0] w, input bit gap);
    if (d == 0) exp_q0.push_back({addr, w});
    else        exp_q1.push_back({addr, w});
    send_byte(d, w[7:0], gap);
    send_byte(d, w[15:8], gap);
    send_byte(d, w[23:16], gap);
    send_byte(d, w[31:24], gap);
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (done_s[d] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("done_dut%0d", d), {31'd0, done_s[d]}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d]    = 1'b0;
      in_valid_s[d] = 1'b0;
      in_data_s[d]  = 8'h00;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", {31'd0, in_ready_s[d]}, 32'd0);
      check("rst_mem_we",   {31'd0, mem_we_s[d]},   32'd0);
      check("rst_busy",     {31'd0, busy_s[d]},     32'd0);
      check("rst_done",     {31'd0, done_s[d]},     32'd0);
      check("rst_err",      {31'd0, err_s[d]},      32'd0);
      check("rst_words",    words_s[d],             32'd0);
      check("rst_addr",     mem_addr_s[d],          32'd0);
      check("rst_wdata",    mem_wdata_s[d],         32'd0);
      check("rst_state",    {29'd0, state_s[d]},    32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Two-word load at BASE 0, with a start pulse mid-load that must be ignored.
    pulse_start(0);
    check("busy_after_start", {31'd0, busy_s[0]}, 32'd1);
    check("words_at_start",   words_s[0],         32'd0);
    send_word(0, 32'h0, 32'h0000_0013, 1'b0);
    pulse_start(0);
    check("busy_mid_load",  {31'd0, busy_s[0]}, 32'd1);
    check("words_mid_load", words_s[0],         32'd1);
    send_word(0, 32'h4, 32'h0010_0093, 1'b0);
    wait_done(0);
    check("words_final",  words_s[0],           32'd2);
    check("busy_done",    {31'd0, busy_s[0]},   32'd0);
    check("ready_done",   {31'd0, in_ready_s[0]}, 32'd0);
    check("addr_held",    mem_addr_s[0],        32'h4);
    check("wdata_held",   mem_wdata_s[0],       32'h0010_0093);
    check("err_nochk",    {31'd0, err_s[0]},    32'd0);

    // One-word load at BASE 0x100 with in_valid toggling every other cycle.
    pulse_start(1);
    send_word(1, 32'h100, 32'hDEAD_BEEF, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(1, 8'h38, 1'b0);
`endif
    wait_done(1);
    check("words_dut1", words_s[1],         32'd1);
    check("err_dut1",   {31'd0, err_s[1]},  32'd0);

`ifdef LOADER_CHECKSUM_EN
    pulse_start(1);
    check("done_clear", {31'd0, done_s[1]}, 32'd0);
    send_word(1, 32'h100, 32'h0403_0201, 1'b0);
    send_byte(1, 8'h0A, 1'b0);
    wait_done(1);
    check("chk_good_err", {31'd0, err_s[1]}, 32'd0);
    pulse_start(1);
    check("err_clear", {31'd0, err_s[1]}, 32'd0);
    send_word(1, 32'h100, 32'h0403_0201, 1'b0);
    send_byte(1, 8'h0B, 1'b0);
    wait_done(1);
    check("chk_bad_err", {31'd0, err_s[1]}, 32'd1);
`endif

    // Restart from DONE, reset after two bytes: no write may follow, then reload from BASE.
    pulse_start(0);
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, in_ready_s[0]}, 32'd0);
    check("rst_mid_state", {29'd0, state_s[0]},    32'd0);
    check("rst_mid_busy",  {31'd0, busy_s[0]},     32'd0);
    check("rst_mid_words", words_s[0],             32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_state", {29'd0, state_s[0]}, 32'd0);
    check("post_rst_addr",  mem_addr_s[0],       32'd0);
    pulse_start(0);
    send_word(0, 32'h0, 32'h1122_3344, 1'b0);
    send_word(0, 32'h4, 32'h8765_4321, 1'b0);
    wait_done(0);
    check("reload_words", words_s[0], 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("q0_empty", exp_q0.size(), 32'd0);
    check("q1_empty", exp_q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0: byte address of the first word written; SHALL be a multiple of 4.
REQ-002 Parameter NUM_WORDS, default 1024: number of 32-bit words per load; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new load; sampled only in IDLE or DONE.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both high.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  32  byte address of the write; always a multiple of 4.
REQ-011 mem_wdata  output  32  word to write.
REQ-012 busy  output  1  high from the cycle after start is accepted until the load completes.
REQ-013 done  output  1  high while in DONE.
REQ-014 words_written  output  32  count of words written in the current or last load.
REQ-015 err  output  1  checksum mismatch flag (see Configuration).

Function
REQ-016 FSM states: IDLE, COLLECT, WRITE, CHECK (only when the checksum feature is compiled in), DONE.
REQ-017 IDLE/DONE: in_ready=0, mem_we=0; start=1 -> COLLECT; byte index, words_written and err clear to 0; done clears.
REQ-018 COLLECT: in_ready=1; each transfer places in_data little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-019 COLLECT: in_valid low -> no change; no timeout; the stream may stall indefinitely.
REQ-020 On the 4th byte transfer -> WRITE next cycle; in_ready=0 in WRITE.
REQ-021 WRITE lasts exactly one cycle: mem_we=1, mem_addr=BASE_ADDR+4*words_written, mem_wdata=assembled word; words_written increments at the end of that cycle.
REQ-022 After WRITE: if the incremented count equals NUM_WORDS -> DONE (or CHECK when enabled), else -> COLLECT.
REQ-023 Latency: mem_we asserts exactly 1 cycle after the 4th byte transfer; with in_valid held high, throughput is 1 word per 5 cycles.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-025 start while busy SHALL be ignored; start in DONE begins a new load from BASE_ADDR.
REQ-026 words_written arithmetic is 32-bit; address arithmetic wraps modulo 2^32.

Reset
REQ-027 Asserting reset SHALL, asynchronously: set state=IDLE, in_ready=0, mem_we=0, busy=0, done=0, err=0, words_written=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset during COLLECT or WRITE SHALL discard the partial word and issue no further write; memory contents already written are untouched.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: after the last WRITE, enter CHECK with in_ready=1; accept one byte; err=1 if it differs from the 8-bit modulo-256 sum of all data bytes, else 0; then DONE.
REQ-030 LOADER_CHECKSUM_EN undefined: no CHECK state and no running sum; the last WRITE goes directly to DONE; err tied to 0.

Verification
REQ-031 NUM_WORDS=2, BASE_ADDR=0; start, then bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0, 0x00100093 @0x4; done=1; words_written=2.
REQ-032 BASE_ADDR=0x100, NUM_WORDS=1, in_valid toggled every other cycle -> single write 0x??? assembled correctly @0x100; mem_we high exactly 1 cycle.
REQ-033 Reset asserted after 2 bytes of word 0 -> no mem_we ever; state IDLE; in_ready=0 immediately; a subsequent start reloads from BASE_ADDR.
REQ-034 start pulsed mid-load -> ignored; address sequence continues unchanged.
REQ-035 LOADER_CHECKSUM_EN, NUM_WORDS=1, bytes 01 02 03 04 then checksum 0x0A -> err=0; checksum 0x0B -> err=1; both end in DONE.
